// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Runtime-programmable serial sequence detector for the bit-stream front end.
// A pattern of up to MAX_LEN bits, its length and an overlap/non-overlap mode
// are loaded with a single-cycle strobe. Serial bits qualified by in_valid are
// shifted into a history register and compared against the active pattern
// every accepted cycle. A hit produces a registered one-cycle match pulse and
// (optionally) bumps a saturating match counter.
//
// Build option:
//   SEQDET_MATCH_COUNT_EN  defined   -> CNT_W-bit saturating match counter
//                          undefined -> no counter logic, match_count tied to 0
//
// Parameters:
//   MAX_LEN      maximum pattern length in bits (2..32)
//   DEF_PATTERN  pattern after reset (low DEF_LEN bits are significant)
//   DEF_LEN      pattern length after reset
//   DEF_OVERLAP  mode after reset (1 = overlapping, 0 = non-overlapping)
//   CNT_W        width of the match counter
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   cfg_load     single-cycle strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  pattern; bit cfg_len-1 is received first, bit 0 last
//   cfg_len      pattern length (0 disables detection, > MAX_LEN is clamped)
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   in_valid     qualifies in_bit
//   in_bit       serial data
//   match        registered one-cycle pulse per detected sequence
//   match_count  saturating count of matches since reset / last load
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0101_1010,
    parameter int                 DEF_LEN     = 7,
    parameter bit                 DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 16,
    localparam int                LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    // Length constants expressed in the width of the length/fill registers.
    localparam logic [LW-1:0] MAX_LEN_C = LW'(MAX_LEN);
    localparam logic [LW-1:0] DEF_LEN_C = (DEF_LEN > MAX_LEN) ? LW'(MAX_LEN) : LW'(DEF_LEN);

    // Active configuration
    logic [MAX_LEN-1:0] pat_r;
    logic [LW-1:0]      len_r;
    logic               ovl_r;

    // Stream state
    logic [MAX_LEN-1:0] hist_r;
    logic [LW-1:0]      fill_r;
    logic               match_r;

    // Combinational datapath
    logic [LW-1:0]      cfg_len_clamped_s;
    logic               accept_s;
    logic [MAX_LEN-1:0] win_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               window_eq_s;
    logic [LW:0]        fill_inc_s;
    logic               fill_ok_s;
    logic               hit_s;
    logic [LW-1:0]      fill_nxt_s;

    // A bit is only consumed when no configuration load competes for the edge.
    assign accept_s = in_valid & ~cfg_load;

    // Candidate window: history shifted left with the new bit entering at bit 0.
    assign win_s = {hist_r[MAX_LEN-2:0], in_bit};

    // Clamp an oversize load length to the physical history depth.
    always_comb begin
        if (cfg_len > MAX_LEN_C) begin
            cfg_len_clamped_s = MAX_LEN_C;
        end else begin
            cfg_len_clamped_s = cfg_len;
        end
    end

    // Thermometer mask selecting the low len_r bits that take part in a compare.
    always_comb begin
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < len_r) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    // Compare only the significant window bits against the pattern.
    assign window_eq_s = (((win_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});

    // The window must consist of enough bits accepted since the last clear;
    // one extra bit of width keeps fill+1 from wrapping at MAX_LEN.
    assign fill_inc_s = {1'b0, fill_r} + {{LW{1'b0}}, 1'b1};
    assign fill_ok_s  = (fill_inc_s >= {1'b0, len_r});

    // A zero length disables detection while the shift path keeps running.
    assign hit_s = accept_s & window_eq_s & fill_ok_s & (len_r != {LW{1'b0}});

    // Next fill: a non-overlapping hit restarts the count so the next match
    // needs a completely fresh pattern; otherwise count up and saturate.
    always_comb begin
        if (hit_s && !ovl_r) begin
            fill_nxt_s = {LW{1'b0}};
        end else if (fill_r == MAX_LEN_C) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_inc_s[LW-1:0];
        end
    end

    // Active configuration registers: defaults on reset, replaced by a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r <= DEF_PATTERN;
            len_r <= DEF_LEN_C;
            ovl_r <= DEF_OVERLAP;
        end else if (cfg_load) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len_clamped_s;
            ovl_r <= cfg_overlap;
        end else begin
            pat_r <= pat_r;
            len_r <= len_r;
            ovl_r <= ovl_r;
        end
    end

    // History and fill: cleared by reset or load, advanced on accepted bits,
    // held on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LW{1'b0}};
        end else if (cfg_load) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LW{1'b0}};
        end else if (accept_s) begin
            hist_r <= win_s;
            fill_r <= fill_nxt_s;
        end else begin
            hist_r <= hist_r;
            fill_r <= fill_r;
        end
    end

    // Registered match pulse; hit_s is already low on idle and load cycles,
    // so every pulse lasts exactly one cycle per hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_r <= 1'b0;
        end else if (cfg_load) begin
            match_r <= 1'b0;
        end else begin
            match_r <= hit_s;
        end
    end

    assign match = match_r;

`ifdef SEQDET_MATCH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Saturating hit counter, updated on the same edge as the match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (cfg_load) begin
            count_r <= {CNT_W{1'b0}};
        end else if (hit_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign match_count = count_r;
`else
    assign match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Two detector instances share one stimulus stream: one with the default
// 16-bit counter and one with a 2-bit counter to exercise saturation. A
// behavioural model keeps the accepted bit stream in a queue and decides a
// hit by comparing the last len bits against the pattern, with a count of
// bits seen since the last non-overlapping match.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        in_valid;
    logic        in_bit;
    logic        match_a;
    logic [15:0] count_a;
    logic        match_b;
    logic [1:0]  count_b;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pat;
    int m_len;
    bit m_ovl;
    bit m_bits[$];
    int m_since;
    bit m_match;
    int m_cnt;

    seq_detect_param dut_a (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .match(match_a), .match_count(count_a)
    );

    seq_detect_param #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .match(match_b), .match_count(count_b)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt(input int n, input int maxv);
`ifdef SEQDET_MATCH_COUNT_EN
        return (n > maxv) ? maxv : n;
`else
        return 0;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_match_a"}, 32'(match_a), 32'(m_match));
        check_val({tag, "_match_b"}, 32'(match_b), 32'(m_match));
        check_val({tag, "_count_a"}, 32'(count_a), 32'(exp_cnt(m_cnt, 65535)));
        check_val({tag, "_count_b"}, 32'(count_b), 32'(exp_cnt(m_cnt, 3)));
    endtask

    task automatic model_clear();
        m_bits.delete();
        m_since = 0;
        m_match = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_defaults();
        m_pat = 'h5A;
        m_len = 7;
        m_ovl = 1'b1;
        model_clear();
    endtask

    // A hit is: detection enabled, at least len bits since the last restart,
    // and the most recent len bits equal the pattern (pattern bit 0 = newest).
    task automatic model_accept(input bit b);
        bit hit;
        m_bits.push_back(b);
        if (m_bits.size() > 40) void'(m_bits.pop_front());
        m_since++;
        hit = 1'b0;
        if (m_len != 0 && m_since >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++) begin
                if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            end
        end
        if (hit && !m_ovl) m_since = 0;
        m_match = hit;
        if (hit) m_cnt++;
    endtask

    task automatic step(input bit v, input bit b);
        in_valid = v;
        in_bit   = b;
        cfg_load = 1'b0;
        @(posedge clk);
        if (v) model_accept(b);
        else   m_match = 1'b0;
        #1;
        check_outputs("step");
    endtask

    task automatic send_seq(input logic [31:0] v, input int n);
        logic [31:0] val;
        val = v;
        for (int i = n - 1; i >= 0; i--) step(1'b1, val[i]);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        in_valid    = 1'($urandom_range(0, 1));
        in_bit      = 1'($urandom_range(0, 1));
        @(posedge clk);
        m_pat = int'(p);
        m_len = (l > 4'd8) ? 8 : int'(l);
        m_ovl = o;
        model_clear();
        #1;
        check_outputs("load");
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_defaults();
        check_outputs("rst_async");
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        model_defaults();
        #1;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Defaults, overlapping: 1011010_11010
        send_seq(32'b1011_0101_1010, 12);
        check_val("plan1_count", 32'(count_a), 32'(exp_cnt(2, 65535)));

        // Non-overlapping 1011010
        load(8'b0101_1010, 4'd7, 1'b0);
        send_seq(32'b10_1101_0110_1010, 14);
        check_val("plan2a_count", 32'(count_a), 32'(exp_cnt(1, 65535)));
        load(8'b0101_1010, 4'd7, 1'b0);
        send_seq(32'b10_1101_0101_1010, 14);
        check_val("plan2b_count", 32'(count_a), 32'(exp_cnt(2, 65535)));

        // Default pattern with three idle cycles between bits 4 and 5
        async_reset();
        send_seq(32'b1011, 4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));
        send_seq(32'b010, 3);
        check_val("plan3_match", 32'(match_a), 32'd1);
        step(1'b0, 1'b0);
        check_val("plan3_count", 32'(count_a), 32'(exp_cnt(1, 65535)));

        // Four ones, overlapping then non-overlapping
        load(8'h0F, 4'd4, 1'b1);
        send_seq(32'hFF, 8);
        check_val("plan4a_count", 32'(count_a), 32'(exp_cnt(5, 65535)));
        check_val("plan4a_sat", 32'(count_b), 32'(exp_cnt(5, 3)));
        load(8'h0F, 4'd4, 1'b0);
        send_seq(32'hFF, 8);
        check_val("plan4b_count", 32'(count_a), 32'(exp_cnt(2, 65535)));

        // Partial pattern, async reset, then tail of pattern: no match
        async_reset();
        send_seq(32'b10110, 5);
        async_reset();
        send_seq(32'b10, 2);
        check_val("plan5_count", 32'(count_a), 32'd0);

        // Length corner cases: zero disables, oversize clamps to 8
        load(8'hA5, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)));
        check_val("len0_count", 32'(count_a), 32'd0);
        load(8'hA5, 4'd15, 1'b1);
        send_seq(32'hA5A5, 16);

        // Randomised configurations and streams
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                load(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else if (r < 4) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
